bin2bcd_seq: RTL and testbench
==============================

# bin2bcd_seq

Sequential binary-to-BCD converter that sits directly upstream of the 4-digit 7-segment display multiplexer. It takes a 16-bit binary value, such as the SAP output register zero-extended or a counter, and converts it with a shift-and-add-3 (double-dabble) iteration. The result is presented as a packed 4-digit BCD word, so the display shows decimal instead of hex. The output word is held stable between conversions so the display never shows intermediate digits.

## Interface

Parameters: none. Width is fixed at 16-bit input, 5 internal BCD digits and 4 output digits.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high; returns block to IDLE and clears all outputs.
- start  input  1  conversion request; sampled only in IDLE.
- bin  input  16  binary value; captured on the accepting edge, ignored otherwise.
- busy  output  1  high from the accepting edge until the result is published.
- done  output  1  single-cycle pulse coincident with the `word` update.
- word  output  16  packed BCD, digit3 in [15:12] down to digit0 in [3:0]; feeds the display `word` input.
- ovf  output  1  ten-thousands digit nonzero, i.e. magnitude > 9999; registered with `word`.
- neg  output  1  sign of the last converted value; constant 0 unless signed mode is compiled in.

## Operation

- State machine IDLE -> SHIFT -> DONE -> IDLE.
- **IDLE**
  - `busy` = 0.
  - On `start` = 1: load the shift register {bcd[19:0] = 0, bin_q[15:0] = bin (or its magnitude, see Configuration)}.
  - Clear the iteration count to 0, then go to SHIFT.
- **SHIFT**, one iteration per cycle:
  - Every 4-bit BCD digit >= 5 gets +3 (carry-free per digit, 5 digits).
  - Then the whole 36-bit {bcd, bin_q} register shifts left by 1, and the count increments.
  - After the 16th iteration (count 15 -> done), go to DONE.
- **DONE** (one cycle):
  - `word` <= bcd[15:0], `ovf` <= (bcd[19:16] != 0), `neg` <= captured sign.
  - `done` = 1 this cycle only; next state IDLE.
- `start` asserted while `busy` = 1 (SHIFT or DONE) is ignored; no queuing.
- `word`, `ovf` and `neg` change only in DONE and hold indefinitely otherwise.
- Values 10000–65535 produce the low 4 digits in `word` plus `ovf` = 1. Example: 65535 gives `word` = 16'h5535.
- **Reset mid-operation**: immediate abort; the partial result is discarded and outputs are cleared.

## Timing

Reset values:
- `busy` = 0, `done` = 0, `word` = 16'h0000, `ovf` = 0, `neg` = 0, state IDLE.

Edge numbering, with E0 the edge at which `start` is sampled high in IDLE:
- After E0: `busy` = 1.
- E1..E16: the 16 SHIFT iterations.
- After E16: state DONE.
- After E17: `word`, `ovf` and `neg` are valid, and `done` = 1.
- After E18: `done` = 0, `busy` = 0, IDLE.

Throughput:
- Latency from the start edge to a valid `word` is 17 cycles.
- The earliest next accepted start is E18, so back-to-back throughput is one conversion per 18 cycles.
- With `start` held high continuously, the block re-converts every 18 cycles.

Other rules:
- `done` and `busy` are registered outputs.
- `bin` need only be stable at E0.

## Configuration

Macro `BIN2BCD_SIGNED_EN`.

Defined:
- `bin` is two's complement. At E0 the block captures sign = bin[15] and loads |bin| (unsigned 16-bit; 16'h8000 gives magnitude 32768).
- `neg` reports the sign.

Undefined:
- `bin` is unsigned and `neg` is tied to 0.

All other behaviour and timing are identical in both builds.

## Test plan

- **Reset**: assert `reset` asynchronously between edges -> `word` = 0000, `busy` = 0, `done` = 0, `ovf` = 0, `neg` = 0 immediately.
- **Basic conversion**: `bin` = 1234, `start` pulse -> exactly 17 cycles later `word` = 16'h1234, `ovf` = 0, one-cycle `done`; `busy` high for 18 cycles.
- **Boundaries**:
  - 0 -> 16'h0000.
  - 9999 -> 16'h9999, `ovf` = 0.
  - 10000 -> 16'h0000, `ovf` = 1.
  - 65535 -> 16'h5535, `ovf` = 1.
- **Start while busy**: convert 42, then at cycle 5 assert `start` with `bin` = 777 -> result 16'h0042 only, no second `done`, and `word` holds its old value until E17.
- **Reset mid-conversion**: `start` with 4321, then reset at cycle 8 -> outputs cleared; a fresh `start` with 56 -> 16'h0056 after 17 cycles.
- **Signed mode** (`BIN2BCD_SIGNED_EN` defined):
  - 16'hFFFF -> `word` = 0001, `neg` = 1.
  - 16'h8000 -> `word` = 2768, `ovf` = 1, `neg` = 1.
  - 16'h007B -> `word` = 0123, `neg` = 0.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// Sequential 16-bit binary to 4-digit packed BCD converter (double-dabble, one bit per cycle).
// Optional signed input handling is enabled by defining BIN2BCD_SIGNED_EN.
module bin2bcd_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] bin,
  output logic        busy,
  output logic        done,
  output logic [15:0] word,
  output logic        ovf,
  output logic        neg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [35:0] sr_q, sr_d;     // {bcd[19:0], bin[15:0]}
  logic [35:0] sr_adj;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] word_q, word_d;
  logic        ovf_q, ovf_d;
  logic [15:0] load_val;

`ifdef BIN2BCD_SIGNED_EN
  logic sign_q, sign_d;
  logic neg_q, neg_d;

  // Two's-complement magnitude; 16'h8000 maps to 32768, which still fits unsigned.
  assign load_val = bin[15] ? (~bin + 16'd1) : bin;
  assign neg      = neg_q;
`else
  assign load_val = bin;
  assign neg      = 1'b0;
`endif

  always_comb begin
    sr_adj = sr_q;
    for (int unsigned i = 0; i < 5; i++) begin
      if (sr_q[16 + 4*i +: 4] >= 4'd5) begin
        sr_adj[16 + 4*i +: 4] = sr_q[16 + 4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    word_d  = word_q;
    ovf_d   = ovf_q;
`ifdef BIN2BCD_SIGNED_EN
    sign_d  = sign_q;
    neg_d   = neg_q;
`endif
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          sr_d    = {20'd0, load_val};
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
`ifdef BIN2BCD_SIGNED_EN
          sign_d  = bin[15];
`endif
        end
      end
      SHIFT: begin
        busy_d = 1'b1;
        sr_d   = {sr_adj[34:0], 1'b0};
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // busy stays registered high through the publish cycle; it drops one edge later in IDLE.
        busy_d  = 1'b1;
        done_d  = 1'b1;
        word_d  = sr_q[31:16];
        ovf_d   = |sr_q[35:32];
        state_d = IDLE;
`ifdef BIN2BCD_SIGNED_EN
        neg_d   = sign_q;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      word_q  <= '0;
      ovf_q   <= 1'b0;
`ifdef BIN2BCD_SIGNED_EN
      sign_q  <= 1'b0;
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      word_q  <= word_d;
      ovf_q   <= ovf_d;
`ifdef BIN2BCD_SIGNED_EN
      sign_q  <= sign_d;
      neg_q   <= neg_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign word = word_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: vector table, random values against a decimal-arithmetic model,
// and hand-written sequences for reset, start-while-busy and continuous start.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] bin;
  logic        busy, done, ovf, neg;
  logic [15:0] word;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] exp_word_q = '0;
  logic        exp_ovf_q  = 1'b0;
  logic        exp_neg_q  = 1'b0;

  typedef struct {
    logic [15:0] bin;
    logic [15:0] word;
    logic        ovf;
    logic        neg;
  } vec_t;

  vec_t tbl[6];

  bin2bcd_seq dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .word  (word),
    .ovf   (ovf),
    .neg   (neg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: decimal digits by division; returns {neg, ovf, word}.
  function automatic logic [17:0] model(input logic [15:0] v);
    int unsigned mag;
    logic        s;
    logic [15:0] w;
`ifdef BIN2BCD_SIGNED_EN
    s   = v[15];
    mag = s ? (32'd65536 - 32'(v)) : 32'(v);
`else
    s   = 1'b0;
    mag = 32'(v);
`endif
    w = 16'(((mag / 1000) % 10) * 4096 + ((mag / 100) % 10) * 256 +
            ((mag / 10) % 10) * 16 + (mag % 10));
    return {s, (mag > 9999), w};
  endfunction

  // One full conversion with cycle-exact checks; inj > 0 pulses start (bin=777) before edge E<inj>.
  task automatic do_conv(input logic [15:0] v, input int inj);
    logic [17:0] e;
    bit busy_ok, done_ok, stable_ok;
    e = model(v);
    busy_ok = 1; done_ok = 1; stable_ok = 1;
    @(negedge clk);
    bin   = v;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_E0", busy, 1);
    for (int c = 1; c <= 16; c++) begin
      if (c == inj) begin
        start = 1'b1;
        bin   = 16'd777;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (busy !== 1'b1) busy_ok = 0;
      if (done !== 1'b0) done_ok = 0;
      if (word !== exp_word_q || ovf !== exp_ovf_q || neg !== exp_neg_q) stable_ok = 0;
    end
    chk("busy_E1_E16", 32'(busy_ok), 1);
    chk("done_low_E1_E16", 32'(done_ok), 1);
    chk("outputs_held_E1_E16", 32'(stable_ok), 1);
    @(posedge clk); #1;
    chk("done_E17", done, 1);
    chk("busy_E17", busy, 1);
    chk("word_E17", word, e[15:0]);
    chk("ovf_E17", ovf, e[16]);
    chk("neg_E17", neg, e[17]);
    exp_word_q = e[15:0];
    exp_ovf_q  = e[16];
    exp_neg_q  = e[17];
    @(posedge clk); #1;
    chk("done_E18", done, 0);
    chk("busy_E18", busy, 0);
  endtask

  initial begin
    int first, second;
    bit quiet_ok;

`ifdef BIN2BCD_SIGNED_EN
    tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b1};
    tbl[1] = '{16'h8000, 16'h2768, 1'b1, 1'b1};
    tbl[2] = '{16'h007B, 16'h0123, 1'b0, 1'b0};
    tbl[3] = '{16'd0,    16'h0000, 1'b0, 1'b0};
    tbl[4] = '{16'd9999, 16'h9999, 1'b0, 1'b0};
    tbl[5] = '{16'hD8F0, 16'h0000, 1'b1, 1'b1};
`else
    tbl[0] = '{16'd1234,  16'h1234, 1'b0, 1'b0};
    tbl[1] = '{16'd0,     16'h0000, 1'b0, 1'b0};
    tbl[2] = '{16'd9999,  16'h9999, 1'b0, 1'b0};
    tbl[3] = '{16'd10000, 16'h0000, 1'b1, 1'b0};
    tbl[4] = '{16'd65535, 16'h5535, 1'b1, 1'b0};
    tbl[5] = '{16'd100,   16'h0100, 1'b0, 1'b0};
`endif

    reset = 1'b1;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_word", word, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_neg", neg, 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      do_conv(tbl[i].bin, 0);
      chk("tbl_word", word, tbl[i].word);
      chk("tbl_ovf", ovf, tbl[i].ovf);
      chk("tbl_neg", neg, tbl[i].neg);
    end

    for (int i = 0; i < 20; i++) begin
      do_conv(16'($urandom_range(0, 65535)), 0);
    end

    // Start while busy: the second request must be dropped.
    do_conv(16'd42, 5);
    quiet_ok = 1;
    repeat (25) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0 || word !== exp_word_q) quiet_ok = 0;
    end
    chk("ignored_start_quiet", 32'(quiet_ok), 1);
    chk("ignored_start_word", word, model(16'd42));

    // Reset mid-conversion, asserted between edges.
    @(negedge clk);
    bin   = 16'd4321;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("async_rst_word", word, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_ovf", ovf, 0);
    chk("async_rst_neg", neg, 0);
    exp_word_q = '0;
    exp_ovf_q  = 1'b0;
    exp_neg_q  = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    do_conv(16'd56, 0);
    chk("after_rst_word", word, 16'h0056);

    // Continuous start: one conversion every 18 cycles.
    first  = -1;
    second = -1;
    @(negedge clk);
    bin   = 16'd1;
    start = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
    end
    start = 1'b0;
    chk("held_first_done", 32'(first), 32'd17);
    chk("held_period", 32'(second - first), 32'd18);
    repeat (25) @(posedge clk);
    #1;
    chk("held_word", word, 16'h0001);
    chk("held_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
